apsk_llr_serializer: RTL and testbench

Downstream stage of the exhaustive APSK demapper. It consumes the per-bit minimum-metric pairs produced by the min-comparator trees: for each bit k, min over points with bit k = 0 and min over points with bit k = 1. Per symbol it forms scaled, saturated LLRs and streams them out one bit per cycle over a valid/ready interface. The number of bits per symbol follows the modulation mode latched at symbol acceptance.

---
 rtl/apsk_llr_serializer_if.sv | 33 +++
 rtl/apsk_llr_serializer.sv | 108 ++++++++++
 tb/tb_apsk_llr_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/apsk_llr_serializer_if.sv
// Symbol-side and LLR-side handshake bundle for the APSK LLR serializer.
// slave = serializer view, master = producer/consumer (bench) view.
interface apsk_llr_serializer_if #(
  parameter int wordlength = 18,
  parameter int LLR_W      = 8
);
  logic                         i_valid;
  logic                         o_in_ready;
  logic [1:0]                   i_mode;
  logic signed [wordlength-1:0] i_min0_0, i_min0_1, i_min0_2, i_min0_3, i_min0_4;
  logic signed [wordlength-1:0] i_min1_0, i_min1_1, i_min1_2, i_min1_3, i_min1_4;
  logic                         o_llr_valid;
  logic                         i_llr_ready;
  logic signed [LLR_W-1:0]      o_llr;
  logic [2:0]                   o_llr_idx;
  logic                         o_llr_last;

  modport slave (
    input  i_valid, i_mode,
    input  i_min0_0, i_min0_1, i_min0_2, i_min0_3, i_min0_4,
    input  i_min1_0, i_min1_1, i_min1_2, i_min1_3, i_min1_4,
    input  i_llr_ready,
    output o_in_ready, o_llr_valid, o_llr, o_llr_idx, o_llr_last
  );

  modport master (
    output i_valid, i_mode,
    output i_min0_0, i_min0_1, i_min0_2, i_min0_3, i_min0_4,
    output i_min1_0, i_min1_1, i_min1_2, i_min1_3, i_min1_4,
    output i_llr_ready,
    input  o_in_ready, o_llr_valid, o_llr, o_llr_idx, o_llr_last
  );
endinterface

// File: rtl/apsk_llr_serializer.sv
// Turns per-bit min-metric pairs into scaled, saturated LLRs and streams
// them out one bit per cycle; bits per symbol follow the mode at acceptance.
module apsk_llr_serializer #(
  parameter int wordlength = 18,
  parameter int LLR_W      = 8,
  parameter int FRAC_SHIFT = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apsk_llr_serializer_if.slave  bus
);
  localparam int NUM_LANES = 5;

  // Symmetric clip: -2^(LLR_W-1) is never emitted.
  localparam logic signed [wordlength:0] SAT_P =
    {{(wordlength+2-LLR_W){1'b0}}, {(LLR_W-1){1'b1}}};
  localparam logic signed [wordlength:0] SAT_N = -SAT_P;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                               state_q, state_d;
  logic [NUM_LANES-1:0][LLR_W-1:0]      buf_q, buf_d, lane_llr;
  logic [NUM_LANES-1:0][wordlength-1:0] min0, min1;
  logic [2:0]                           idx_q, idx_d;
  logic [2:0]                           nbits_q, nbits_d;
  logic [2:0]                           last_idx;
  logic signed [LLR_W-1:0]              llr_q, llr_d;
  logic                                 valid_q, valid_d;
  logic                                 last_q, last_d;
  logic                                 in_ready, accept, hs;

  assign min0 = {bus.i_min0_4, bus.i_min0_3, bus.i_min0_2, bus.i_min0_1, bus.i_min0_0};
  assign min1 = {bus.i_min1_4, bus.i_min1_3, bus.i_min1_2, bus.i_min1_1, bus.i_min1_0};

  // Per-lane difference, arithmetic shift (floor) and symmetric saturation.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [wordlength:0] diff, shf;
    assign diff = $signed({min1[k][wordlength-1], min1[k]})
                - $signed({min0[k][wordlength-1], min0[k]});
    assign shf  = diff >>> FRAC_SHIFT;
    assign lane_llr[k] = (shf > SAT_P) ? SAT_P[LLR_W-1:0] :
                         (shf < SAT_N) ? SAT_N[LLR_W-1:0] :
                                         shf[LLR_W-1:0];
  end

  assign last_idx = nbits_q - 3'd1;
  assign hs       = valid_q && bus.i_llr_ready;
  // Combinational from i_llr_ready so symbols chain with no bubble.
  assign in_ready = (state_q == IDLE) || (valid_q && last_q && bus.i_llr_ready);
  assign accept   = bus.i_valid && in_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    nbits_d = nbits_q;
    llr_d   = llr_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      state_d = SEND;
      buf_d   = lane_llr;
      nbits_d = {1'b0, bus.i_mode} + 3'd2;
      idx_d   = 3'd0;
      llr_d   = lane_llr[0];
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (hs) begin
      if (last_q) begin
        state_d = IDLE;
        idx_d   = 3'd0;
        llr_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d   = idx_q + 3'd1;
        llr_d   = buf_q[idx_d];
        last_d  = (idx_d == last_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= 3'd0;
      nbits_q <= 3'd2;
      llr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      nbits_q <= nbits_d;
      llr_q   <= llr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_llr_valid = valid_q;
  assign bus.o_llr       = llr_q;
  assign bus.o_llr_idx   = idx_q;
  assign bus.o_llr_last  = last_q;
endmodule

// File: tb/tb_apsk_llr_serializer.sv
// Directed bench for apsk_llr_serializer: queue-based LLR model checked every
// cycle, plus literal expectations on the documented scenarios.
module tb_apsk_llr_serializer;
  localparam int WL   = 18;
  localparam int LW   = 8;
  localparam int FRAC = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apsk_llr_serializer_if #(.wordlength(WL), .LLR_W(LW)) bus ();

  apsk_llr_serializer #(.wordlength(WL), .LLR_W(LW), .FRAC_SHIFT(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^FRAC, then clip to +-(2^(LW-1)-1).
  function automatic int llr_of(input int m0, input int m1);
    int d, q, lim;
    d   = m1 - m0;
    q   = (d >= 0) ? d / (1 << FRAC) : -((-d + (1 << FRAC) - 1) / (1 << FRAC));
    lim = (1 << (LW - 1)) - 1;
    if (q > lim)  q = lim;
    if (q < -lim) q = -lim;
    return q;
  endfunction

  typedef struct { int llr; int idx; bit last; } exp_t;
  exp_t exp_q[$];
  int   sm0[5], sm1[5];

  function automatic bit model_ready();
    if (exp_q.size() == 0) return 1'b1;
    return exp_q[0].last && bus.i_llr_ready;
  endfunction

  // Expected-output queue: one entry per LLR still to be emitted.
  bit   m_rdy;
  int   m_nb;
  int   a0[5], a1[5];
  exp_t e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else begin
      m_rdy = model_ready();
      if (exp_q.size() > 0 && bus.i_llr_ready) void'(exp_q.pop_front());
      if (bus.i_valid && m_rdy) begin
        a0 = '{int'(bus.i_min0_0), int'(bus.i_min0_1), int'(bus.i_min0_2),
               int'(bus.i_min0_3), int'(bus.i_min0_4)};
        a1 = '{int'(bus.i_min1_0), int'(bus.i_min1_1), int'(bus.i_min1_2),
               int'(bus.i_min1_3), int'(bus.i_min1_4)};
        m_nb = int'(bus.i_mode) + 2;
        for (int k = 0; k < m_nb; k++) begin
          e.llr  = llr_of(a0[k], a1[k]);
          e.idx  = k;
          e.last = (k == m_nb - 1);
          exp_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", int'(bus.o_llr_valid), 0);
      chk("rst_llr",   int'(bus.o_llr), 0);
      chk("rst_idx",   int'(bus.o_llr_idx), 0);
      chk("rst_last",  int'(bus.o_llr_last), 0);
      chk("rst_ready", int'(bus.o_in_ready), 1);
    end else begin
      chk("valid", int'(bus.o_llr_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0 && bus.o_llr_valid) begin
        chk("llr",  int'($signed(bus.o_llr)), exp_q[0].llr);
        chk("idx",  int'(bus.o_llr_idx), exp_q[0].idx);
        chk("last", int'(bus.o_llr_last), int'(exp_q[0].last));
      end
      chk("in_ready", int'(bus.o_in_ready), int'(model_ready()));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic apply_sym(input int mode);
    bus.i_mode   = 2'(mode);
    bus.i_min0_0 = WL'(sm0[0]); bus.i_min1_0 = WL'(sm1[0]);
    bus.i_min0_1 = WL'(sm0[1]); bus.i_min1_1 = WL'(sm1[1]);
    bus.i_min0_2 = WL'(sm0[2]); bus.i_min1_2 = WL'(sm1[2]);
    bus.i_min0_3 = WL'(sm0[3]); bus.i_min1_3 = WL'(sm1[3]);
    bus.i_min0_4 = WL'(sm0[4]); bus.i_min1_4 = WL'(sm1[4]);
  endtask

  task automatic chk_out(input string name, input int llr, input int idx, input int last);
    chk({name, "_valid"}, int'(bus.o_llr_valid), 1);
    chk({name, "_llr"},   int'($signed(bus.o_llr)), llr);
    chk({name, "_idx"},   int'(bus.o_llr_idx), idx);
    chk({name, "_last"},  int'(bus.o_llr_last), last);
  endtask

  initial begin
    // Reset with random inputs
    bus.i_valid = 1'($urandom); bus.i_llr_ready = 1'($urandom);
    for (int k = 0; k < 5; k++) begin
      sm0[k] = int'($urandom_range(0, 200000)) - 100000;
      sm1[k] = int'($urandom_range(0, 200000)) - 100000;
    end
    apply_sym(int'($urandom_range(0, 3)));
    #1 rst_n = 1'b0;
    repeat (3) step();
    look();
    chk("reset_valid", int'(bus.o_llr_valid), 0);
    chk("reset_ready", int'(bus.o_in_ready), 1);
    bus.i_valid = 1'b0; bus.i_llr_ready = 1'b1;
    step(); rst_n = 1'b1;
    repeat (2) step();
    look();
    chk("post_rst_valid", int'(bus.o_llr_valid), 0);
    chk("post_rst_llr",   int'(bus.o_llr), 0);
    chk("post_rst_ready", int'(bus.o_in_ready), 1);

    chk("pin_model_a", llr_of(100, 740), 10);
    chk("pin_model_b", llr_of(131071, -131072), -127);
    chk("pin_model_c", llr_of(1, 0), -1);

    // QPSK basic
    step();
    sm0 = '{100, 740, 0, 0, 0}; sm1 = '{740, 100, 0, 0, 0};
    apply_sym(0); bus.i_valid = 1'b1;
    step(); bus.i_valid = 1'b0;
    look(); chk_out("qpsk0", 10, 0, 0);
    step(); look(); chk_out("qpsk1", -10, 1, 1);
    step(); look(); chk("qpsk_done", int'(bus.o_llr_valid), 0);

    // Saturation / rounding, 8PSK
    sm0 = '{0, 131071, 1, 0, 0}; sm1 = '{131071, -131072, 0, 0, 0};
    apply_sym(1); bus.i_valid = 1'b1;
    step(); bus.i_valid = 1'b0;
    look(); chk_out("sat0", 127, 0, 0);
    step(); look(); chk_out("sat1", -127, 1, 0);
    step(); look(); chk_out("sat2", -1, 2, 1);
    step(); look(); chk("sat_done", int'(bus.o_llr_valid), 0);

    // Backpressure on idx 1, 16APSK, i_valid held
    sm0 = '{0, 0, 0, 0, 0}; sm1 = '{320, -192, 448, 128, 0};
    apply_sym(2); bus.i_valid = 1'b1;
    step();
    sm0 = '{1000, 0, -500, 64, 0}; sm1 = '{0, 50000, -500, 0, 0};
    apply_sym(2);
    look(); chk_out("bp0", 5, 0, 0);
    step(); bus.i_llr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      look();
      chk_out("bp_hold", -3, 1, 0);
      chk("bp_in_ready", int'(bus.o_in_ready), 0);
      step();
    end
    bus.i_llr_ready = 1'b1;
    look(); chk_out("bp_rel", -3, 1, 0);
    step(); look(); chk_out("bp2", 7, 2, 0);
    step(); look(); chk_out("bp3", 2, 3, 1);
    chk("bp3_in_ready", int'(bus.o_in_ready), 1);
    step(); bus.i_valid = 1'b0;
    look(); chk_out("bp_next0", -16, 0, 0);
    repeat (6) step();

    // Back-to-back 32APSK with a transient mode change
    sm0 = '{0, 0, 0, 0, 0}; sm1 = '{64, 128, -64, -8192, 9000};
    apply_sym(3); bus.i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        sm1 = '{-65, 63, 0, 6400, -6400};
        apply_sym(0);
      end
      if (i == 2) bus.i_mode = 2'd3;
      if (i == 5) bus.i_valid = 1'b0;
      look();
      chk("b2b_valid", int'(bus.o_llr_valid), 1);
      chk("b2b_idx",   int'(bus.o_llr_idx), i % 5);
      chk("b2b_last",  int'(bus.o_llr_last), int'(i % 5 == 4));
      if (i == 3) chk("b2b_c3", int'($signed(bus.o_llr)), -127);
      if (i == 4) chk("b2b_c4", int'($signed(bus.o_llr)), 127);
      if (i == 5) chk("b2b_d0", int'($signed(bus.o_llr)), -2);
      if (i == 8) chk("b2b_d3", int'($signed(bus.o_llr)), 100);
    end
    step(); look(); chk("b2b_done", int'(bus.o_llr_valid), 0);

    // Reset while idx 2 of a 32APSK symbol is presented
    sm0 = '{0, 0, 0, 0, 0}; sm1 = '{640, 1280, 1920, 2560, 3200};
    apply_sym(3); bus.i_valid = 1'b1;
    step(); bus.i_valid = 1'b0;
    look(); chk_out("ab0", 10, 0, 0);
    step(); look();
    step(); look(); chk_out("ab2", 30, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_rst_valid", int'(bus.o_llr_valid), 0);
    chk("ab_rst_llr",   int'(bus.o_llr), 0);
    chk("ab_rst_idx",   int'(bus.o_llr_idx), 0);
    chk("ab_rst_last",  int'(bus.o_llr_last), 0);
    step(); rst_n = 1'b1;
    step();
    sm0 = '{0, 0, 0, 0, 0}; sm1 = '{256, -256, 0, 0, 0};
    apply_sym(0); bus.i_valid = 1'b1;
    step(); bus.i_valid = 1'b0;
    look(); chk_out("ab_q0", 4, 0, 0);
    step(); look(); chk_out("ab_q1", -4, 1, 1);
    step(); look(); chk("ab_done", int'(bus.o_llr_valid), 0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
